floo_narrow_reg_responder: RTL
==============================

// Module: floo_narrow_reg_responder
// PURPOSE
//  Terminates the narrow NoC request channel at a tile's Eject port and returns
//  B/R response flits on the narrow response channel. It is the responder end of
//  the narrow AXI-over-NoC protocol that cluster chimneys initiate.
//  Backing store: a NumRegs x 64-bit register file (e.g. tile mailbox/scratch CSRs).
//  One transaction in flight; INCR bursts are supported.
// PARAMETERS
//  NumRegs    16  64-bit words in the register file (power of 2, 2..4096)
//  IdWidth    8   NoC node id width (src/dst)
//  AxiIdWidth 4   AXI transaction id width
//  AddrWidth  48  AXI address width
// PORTS
//  clk_i        in   1           clock
//  rst_ni       in   1           asynchronous active-low reset
//  id_i         in   IdWidth     this node's NoC id
//  req_valid_i  in   1           request flit valid
//  req_ready_o  out  1           request flit accepted when valid&ready
//  req_ch_i     in   2           0=AW 1=W 2=AR 3=reserved
//  req_src_id_i in   IdWidth     initiator node id (AW/AR)
//  req_axi_id_i in   AxiIdWidth  AXI id (AW/AR)
//  req_addr_i   in   AddrWidth   start byte address (AW/AR)
//  req_len_i    in   8           AXI len, beats-1 (AW/AR)
//  req_data_i   in   64          write data (W)
//  req_strb_i   in   8           byte strobes (W)
//  req_last_i   in   1           W last
//  rsp_valid_o  out  1           response flit valid
//  rsp_ready_i  in   1           response flit consumed
//  rsp_ch_o     out  1           0=B 1=R
//  rsp_dst_id_o out  IdWidth     captured req_src_id_i
//  rsp_src_id_o out  IdWidth     id_i
//  rsp_axi_id_o out  AxiIdWidth  captured AXI id
//  rsp_data_o   out  64          read data (0 for B)
//  rsp_resp_o   out  2           00 OKAY, 10 SLVERR
//  rsp_last_o   out  1           last R beat; 1 for B
//  err_o        out  1           one-cycle pulse on protocol error
// BEHAVIOUR
//  Reset: FSM=IDLE, all regs and rsp_* outputs 0, err_o=0. Async reset mid-burst aborts the burst.
//  FSM: IDLE, WDATA, WRESP, RRESP.
//  IDLE: req_ready_o=1. AW -> capture src/id/addr/len, beat=0, werr=0, ->WDATA.
//    AR -> capture, beat=0, ->RRESP. W or ch=3 -> consume and drop, err_o=1.
//  WDATA: req_ready_o = req_valid_i && req_ch_i==W; other channels stall (not consumed).
//    Each W beat writes bytes with strb=1 of word w; beat++. When beat==len: ->WRESP.
//    req_last_i != (beat==len) -> err_o=1; the len counter stays authoritative.
//  WRESP: req_ready_o=0. B flit: resp = werr?SLVERR:OKAY, data=0, last=1. ->IDLE on rsp_ready_i.
//  RRESP: req_ready_o=0. R beat per handshake: data=regs[w] or 0 on error.
//    last=(beat==len); ->IDLE after the last beat handshakes.
//  Word index w = addr[15:3] + beat (13-bit, no wrap). Addr[2:0] and addr[47:16] are ignored.
//    w>=NumRegs -> write dropped, werr=1 / R resp=SLVERR. Each beat is checked independently.
//  Latency: last W accepted in cycle t -> B valid at t+1. AR accepted in t -> first R valid at t+1.
//    Subsequent R beats are back-to-back while rsp_ready_i=1, giving full throughput.
//  rsp_* outputs are registered and held stable while rsp_valid_o && !rsp_ready_i.
//  A W write in cycle t is visible to an AR accepted in cycle t+1 or later.
// TESTING
//  AW addr=0x10 len=0; W data=0xDEAD_BEEF strb=0xFF -> B OKAY one cycle later.
//    AR 0x10 -> R data=0xDEAD_BEEF, last=1, dst_id=src_id.
//  AW 0x0 len=3; 4 W beats 1..4 -> B OKAY. AR 0x0 len=3 -> R 1,2,3,4 back-to-back; last only on beat 4.
//  NumRegs=16: AW 0x78 len=1 -> beat0 writes reg15, beat1 dropped, B=SLVERR.
//    AR 0x78 len=1 -> beat0 OKAY, beat1 SLVERR with data 0.
//  Write strb=0x0F data=0xFFFF_FFFF_FFFF_FFFF over reg holding 0 -> read 0x0000_0000_FFFF_FFFF.
//  R burst with rsp_ready_i low for 3 cycles -> outputs stable; no beat lost or duplicated.
//  Stray W in IDLE -> consumed, err_o 1-cycle pulse, no response. AW during WDATA -> stalled.
//    Reset asserted mid-burst -> IDLE, rsp_valid_o=0.

Source files
------------

// File: rtl/floo_narrow_reg_responder.sv
// Narrow NoC request terminator backed by a NumRegs x 64-bit register file.
// Handles one AW/W or AR transaction at a time and answers with B/R response flits.
module floo_narrow_reg_responder #(
    parameter int unsigned NumRegs    = 16,
    parameter int unsigned IdWidth    = 8,
    parameter int unsigned AxiIdWidth = 4,
    parameter int unsigned AddrWidth  = 48
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [IdWidth-1:0]    id_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_ch_i,
    input  logic [IdWidth-1:0]    req_src_id_i,
    input  logic [AxiIdWidth-1:0] req_axi_id_i,
    input  logic [AddrWidth-1:0]  req_addr_i,
    input  logic [7:0]            req_len_i,
    input  logic [63:0]           req_data_i,
    input  logic [7:0]            req_strb_i,
    input  logic                  req_last_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_ch_o,
    output logic [IdWidth-1:0]    rsp_dst_id_o,
    output logic [IdWidth-1:0]    rsp_src_id_o,
    output logic [AxiIdWidth-1:0] rsp_axi_id_o,
    output logic [63:0]           rsp_data_o,
    output logic [1:0]            rsp_resp_o,
    output logic                  rsp_last_o,
    output logic                  err_o
);
    localparam int unsigned IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;
    localparam logic [1:0] ChAw = 2'd0;
    localparam logic [1:0] ChW  = 2'd1;
    localparam logic [1:0] ChAr = 2'd2;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RRESP} state_e;

    state_e                state_q;
    logic [IdWidth-1:0]    src_q;
    logic [AxiIdWidth-1:0] axi_id_q;
    logic [12:0]           base_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_q;
    logic                  werr_q;
    logic [63:0]           regs [NumRegs];

    // Word indices are 14 bits wide so base + beat never wraps back into range.
    logic [13:0] cur_idx, next_idx, first_idx;
    logic        cur_ok, wr_err;
    logic        unused_addr;

    assign cur_idx     = {1'b0, base_q} + 14'(beat_q);
    assign next_idx    = cur_idx + 14'd1;
    assign first_idx   = {1'b0, req_addr_i[15:3]};
    assign cur_ok      = in_range(cur_idx);
    assign wr_err      = werr_q | ~cur_ok;
    assign unused_addr = ^{req_addr_i[2:0], req_addr_i[AddrWidth-1:16]};

    function automatic logic in_range(input logic [13:0] idx);
        return idx < 14'(NumRegs);
    endfunction

    function automatic logic [63:0] read_word(input logic [13:0] idx);
        return in_range(idx) ? regs[idx[IdxW-1:0]] : 64'd0;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] data,
                                          input logic [7:0] strb);
        logic [63:0] res;
        res = old;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

    always_comb begin
        req_ready_o = 1'b0;
        unique case (state_q)
            IDLE:    req_ready_o = 1'b1;
            WDATA:   req_ready_o = req_valid_i && (req_ch_i == ChW);
            default: req_ready_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            src_q        <= '0;
            axi_id_q     <= '0;
            base_q       <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            werr_q       <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_ch_o     <= 1'b0;
            rsp_dst_id_o <= '0;
            rsp_src_id_o <= '0;
            rsp_axi_id_o <= '0;
            rsp_data_o   <= '0;
            rsp_resp_o   <= '0;
            rsp_last_o   <= 1'b0;
            err_o        <= 1'b0;
            for (int i = 0; i < int'(NumRegs); i++) regs[i] <= '0;
        end else begin
            err_o <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        if (req_ch_i == ChAw || req_ch_i == ChAr) begin
                            src_q    <= req_src_id_i;
                            axi_id_q <= req_axi_id_i;
                            base_q   <= req_addr_i[15:3];
                            len_q    <= req_len_i;
                            beat_q   <= '0;
                            werr_q   <= 1'b0;
                        end
                        if (req_ch_i == ChAw) begin
                            state_q <= WDATA;
                        end else if (req_ch_i == ChAr) begin
                            // First R beat is prepared straight from the AR flit.
                            state_q      <= RRESP;
                            rsp_valid_o  <= 1'b1;
                            rsp_ch_o     <= 1'b1;
                            rsp_dst_id_o <= req_src_id_i;
                            rsp_src_id_o <= id_i;
                            rsp_axi_id_o <= req_axi_id_i;
                            rsp_data_o   <= read_word(first_idx);
                            rsp_resp_o   <= in_range(first_idx) ? RespOkay : RespSlverr;
                            rsp_last_o   <= (req_len_i == 8'd0);
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                WDATA: begin
                    if (req_valid_i && req_ch_i == ChW) begin
                        if (cur_ok) regs[cur_idx[IdxW-1:0]] <=
                            merge(regs[cur_idx[IdxW-1:0]], req_data_i, req_strb_i);
                        werr_q <= wr_err;
                        if (req_last_i != (beat_q == len_q)) err_o <= 1'b1;
                        if (beat_q == len_q) begin
                            state_q      <= WRESP;
                            rsp_valid_o  <= 1'b1;
                            rsp_ch_o     <= 1'b0;
                            rsp_dst_id_o <= src_q;
                            rsp_src_id_o <= id_i;
                            rsp_axi_id_o <= axi_id_q;
                            rsp_data_o   <= '0;
                            rsp_resp_o   <= wr_err ? RespSlverr : RespOkay;
                            rsp_last_o   <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                WRESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                RRESP: begin
                    if (rsp_ready_i) begin
                        if (beat_q == len_q) begin
                            rsp_valid_o <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            beat_q     <= beat_q + 8'd1;
                            rsp_data_o <= read_word(next_idx);
                            rsp_resp_o <= in_range(next_idx) ? RespOkay : RespSlverr;
                            rsp_last_o <= ((beat_q + 8'd1) == len_q);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
